uart_tx_fifo: RTL and testbench

- Byte buffer and launch sequencer directly upstream of the UART transmitter (UART_TX).
- Accepts bytes from system logic in single-cycle write strobes and stores them in a circular FIFO.
- Hands bytes to UART_TX one at a time using UART_TX's i_TX_DV / o_TX_Active / o_TX_Done handshake, so producers never need to track frame timing.

---
 rtl/uart_tx_fifo.sv | 170 +++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 440 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
//   Byte FIFO and launch sequencer sitting in front of a UART transmitter.
//   System logic pushes bytes with single-cycle write strobes. The sequencer
//   pops them one at a time and launches each one into the transmitter using
//   its DV / Active / Done handshake. Producers therefore never need to track
//   frame timing.
//
// Ports
//   i_Clock      system clock (rising edge)
//   i_Reset      synchronous, active-high reset
//   i_Wr_DV      write strobe, one byte per cycle
//   i_Wr_Byte    write data
//   o_Full       occupancy == DEPTH (registered)
//   o_Empty      occupancy == 0 (registered)
//   o_Count      occupancy 0..DEPTH (registered)
//   o_Overflow   sticky: a write was dropped because the FIFO was full
//   o_TX_DV      one-cycle launch pulse to the transmitter
//   o_TX_Byte    byte to the transmitter, held until the next launch
//   i_TX_Active  transmitter busy with a frame
//   i_TX_Done    transmitter frame-complete pulse
//   o_Busy       sequencer is not idle
module uart_tx_fifo #(
    parameter int DEPTH    = 16,
    parameter int ADDR_W   = 4,
    parameter int GAP_CLKS = 2
) (
    input  logic              i_Clock,
    input  logic              i_Reset,
    input  logic              i_Wr_DV,
    input  logic [7:0]        i_Wr_Byte,
    output logic              o_Full,
    output logic              o_Empty,
    output logic [ADDR_W:0]   o_Count,
    output logic              o_Overflow,
    output logic              o_TX_DV,
    output logic [7:0]        o_TX_Byte,
    input  logic              i_TX_Active,
    input  logic              i_TX_Done,
    output logic              o_Busy
);

    localparam int GAP_W = (GAP_CLKS > 1) ? $clog2(GAP_CLKS) : 1;
    localparam logic [ADDR_W:0]  FULL_CNT = (ADDR_W + 1)'(DEPTH);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CLKS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT_DONE,
        S_GAP
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              full_q, full_d;
    logic              empty_q, empty_d;
    logic              ovf_q, ovf_d;
    logic              tx_dv_q, tx_dv_d;
    logic [7:0]        tx_byte_q, tx_byte_d;
    logic              busy_q, busy_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic [7:0]        mem_q [DEPTH];

    logic              wr_en;
    logic              pop;

    // FIFO bookkeeping. Acceptance looks at the registered full flag, so a
    // write that lands in the same cycle as a pop from a full FIFO is still
    // dropped. Pointers wrap naturally because DEPTH == 2**ADDR_W.
    always_comb begin
        wr_en    = i_Wr_DV && !full_q;
        pop      = (state_q == S_LAUNCH);
        wr_ptr_d = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop   ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        case ({wr_en, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        full_d  = (count_d == FULL_CNT);
        empty_d = (count_d == '0);
        ovf_d   = ovf_q || (i_Wr_DV && full_q);
    end

    // Launch sequencer. The DV pulse and the byte are loaded on the edge
    // that enters LAUNCH, so both are flop outputs during the LAUNCH cycle.
    always_comb begin
        state_d   = state_q;
        gap_d     = gap_q;
        tx_dv_d   = 1'b0;
        tx_byte_d = tx_byte_q;
        case (state_q)
            S_IDLE: begin
                if ((count_q != '0) && !i_TX_Active) begin
                    state_d   = S_LAUNCH;
                    tx_dv_d   = 1'b1;
                    tx_byte_d = mem_q[rd_ptr_q];
                end
            end
            S_LAUNCH: begin
                state_d = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (i_TX_Done) begin
                    gap_d   = GAP_LOAD;
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                // Counter is loaded with GAP_CLKS-1, so GAP spans GAP_CLKS cycles.
                if (gap_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state_q   <= S_IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            full_q    <= 1'b0;
            empty_q   <= 1'b1;
            ovf_q     <= 1'b0;
            tx_dv_q   <= 1'b0;
            tx_byte_q <= 8'h00;
            busy_q    <= 1'b0;
            gap_q     <= '0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            full_q    <= full_d;
            empty_q   <= empty_d;
            ovf_q     <= ovf_d;
            tx_dv_q   <= tx_dv_d;
            tx_byte_q <= tx_byte_d;
            busy_q    <= busy_d;
            gap_q     <= gap_d;
        end
    end

    // Storage is not reset. Only the pointers define which entries are valid.
    always_ff @(posedge i_Clock) begin
        if (wr_en && !i_Reset) begin
            mem_q[wr_ptr_q] <= i_Wr_Byte;
        end
    end

    assign o_Full     = full_q;
    assign o_Empty    = empty_q;
    assign o_Count    = count_q;
    assign o_Overflow = ovf_q;
    assign o_TX_DV    = tx_dv_q;
    assign o_TX_Byte  = tx_byte_q;
    assign o_Busy     = busy_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo
//   Drives uart_tx_fifo against a behavioural transmitter. The transmitter
//   holds Active for a random frame length, then pulses Done. A negedge
//   scoreboard keeps a queue-based model of FIFO contents and occupancy and
//   checks every launch against it. Scenario tasks run in sequence.
module tb_uart_tx_fifo;

    localparam int DEPTH    = 16;
    localparam int ADDR_W   = 4;
    localparam int GAP_CLKS = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              wr_dv;
    logic [7:0]        wr_byte;
    logic              full, empty, ovf, tx_dv, busy;
    logic [ADDR_W:0]   count;
    logic [7:0]        tx_byte;
    logic              tx_active, tx_done;
    logic              force_active, force_done;

    logic              uart_active = 1'b0;
    logic              uart_done   = 1'b0;
    int                frame_cnt   = 0;
    logic [7:0]        frame_byte  = 8'h00;
    logic [7:0]        rx_q [$];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign tx_active = uart_active | force_active;
    assign tx_done   = uart_done | force_done;

    uart_tx_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .GAP_CLKS(GAP_CLKS)) dut (
        .i_Clock     (clk),
        .i_Reset     (rst),
        .i_Wr_DV     (wr_dv),
        .i_Wr_Byte   (wr_byte),
        .o_Full      (full),
        .o_Empty     (empty),
        .o_Count     (count),
        .o_Overflow  (ovf),
        .o_TX_DV     (tx_dv),
        .o_TX_Byte   (tx_byte),
        .i_TX_Active (tx_active),
        .i_TX_Done   (tx_done),
        .o_Busy      (busy)
    );

    // Behavioural transmitter: a frame of random length, then a Done pulse.
    // Each completed frame's byte is appended to rx_q.
    always @(posedge clk) begin
        uart_done <= 1'b0;
        if (uart_active) begin
            if (frame_cnt == 0) begin
                uart_active <= 1'b0;
                uart_done   <= 1'b1;
                rx_q.push_back(frame_byte);
            end else begin
                frame_cnt <= frame_cnt - 1;
            end
        end else if (tx_dv) begin
            uart_active <= 1'b1;
            frame_byte  <= tx_byte;
            frame_cnt   <= $urandom_range(40, 16);
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    // Scoreboard. Each negedge it compares the visible status with the model,
    // then applies this cycle's write and launch to the model.
    task automatic monitor();
        int         cyc = 0;
        int         done_cyc = 0;
        bit         done_pend = 0;
        bit         prev_dv = 0;
        int         mdl_cnt = 0;
        bit         mdl_ovf = 0;
        logic [7:0] last_byte = 8'h00;
        logic [7:0] exp_q [$];
        forever begin
            @(negedge clk);
            cyc++;
            checks++;
            if ({count, full, empty, ovf} !== {mdl_cnt[ADDR_W:0], (mdl_cnt == DEPTH), (mdl_cnt == 0), mdl_ovf}) begin
                errors++;
                $display("FAIL status t=%0t count=%0d full=%b empty=%b ovf=%b expected count=%0d ovf=%b",
                         $time, count, full, empty, ovf, mdl_cnt, mdl_ovf);
            end
            if (tx_dv) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL launch_empty t=%0t byte=%h expected no launch", $time, tx_byte);
                end else if (tx_byte !== exp_q[0]) begin
                    errors++;
                    $display("FAIL launch_order t=%0t byte=%h expected %h", $time, tx_byte, exp_q[0]);
                end
                checks++;
                if (prev_dv || tx_active || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL launch_cond t=%0t prev_dv=%b active=%b busy=%b expected 0 0 1",
                             $time, prev_dv, tx_active, busy);
                end
                if (done_pend) begin
                    checks++;
                    if (cyc - done_cyc != GAP_CLKS + 2) begin
                        errors++;
                        $display("FAIL gap_spacing t=%0t done_to_dv=%0d expected %0d",
                                 $time, cyc - done_cyc, GAP_CLKS + 2);
                    end
                    done_pend = 0;
                end
                last_byte = (exp_q.size() != 0) ? exp_q[0] : tx_byte;
            end else begin
                checks++;
                if (tx_byte !== last_byte) begin
                    errors++;
                    $display("FAIL tx_byte_hold t=%0t byte=%h expected %h", $time, tx_byte, last_byte);
                end
            end
            if (tx_done && busy && !force_done && mdl_cnt > 0) begin
                done_cyc  = cyc;
                done_pend = 1;
            end
            prev_dv = tx_dv;
            if (rst) begin
                mdl_cnt   = 0;
                mdl_ovf   = 0;
                last_byte = 8'h00;
                done_pend = 0;
                prev_dv   = 0;
                exp_q.delete();
            end else begin
                if (wr_dv) begin
                    if (mdl_cnt == DEPTH) begin
                        mdl_ovf = 1;
                    end else begin
                        exp_q.push_back(wr_byte);
                        mdl_cnt++;
                    end
                end
                if (tx_dv && exp_q.size() != 0) begin
                    void'(exp_q.pop_front());
                    mdl_cnt--;
                end
            end
        end
    endtask

    // Stimulus helpers; every task starts and ends 1 ns after a rising edge.
    task automatic wr(input logic [7:0] b);
        wr_dv   = 1'b1;
        wr_byte = b;
        @(posedge clk); #1;
        wr_dv   = 1'b0;
    endtask

    task automatic drain(output bit ok);
        ok = 0;
        for (int i = 0; i < 20000; i++) begin
            @(posedge clk); #1;
            if (empty && !busy && !tx_active) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if ({full, empty, count, ovf, tx_dv, tx_byte, busy} !==
            {1'b0, 1'b1, {(ADDR_W + 1){1'b0}}, 1'b0, 1'b0, 8'h00, 1'b0}) begin
            errors++;
            $display("FAIL reset_values full=%b empty=%b count=%0d ovf=%b dv=%b byte=%h busy=%b expected 0 1 0 0 0 00 0",
                     full, empty, count, ovf, tx_dv, tx_byte, busy);
        end
    endtask

    task automatic test_single_byte();
        bit ok;
        int base = rx_q.size();
        wr(8'h3F);
        checks++;
        if (tx_dv !== 1'b0 || count !== 5'd1) begin
            errors++;
            $display("FAIL single_lat1 dv=%b count=%0d expected dv=0 count=1", tx_dv, count);
        end
        @(posedge clk); #1;
        checks++;
        if (tx_dv !== 1'b1 || tx_byte !== 8'h3F) begin
            errors++;
            $display("FAIL single_lat2 dv=%b byte=%h expected dv=1 byte=3f", tx_dv, tx_byte);
        end
        drain(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL single_drain timeout=1 expected 0");
        end
        checks++;
        if (rx_q.size() != base + 1 || rx_q[base] !== 8'h3F || empty !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL single_rx rx_count=%0d empty=%b busy=%b expected 1 byte 3f empty=1 busy=0",
                     rx_q.size() - base, empty, busy);
        end
    endtask

    task automatic test_burst();
        bit ok;
        int base = rx_q.size();
        for (int i = 1; i <= 5; i++) wr(8'(i));
        checks++;
        if (count !== 5'd4) begin
            errors++;
            $display("FAIL burst_count count=%0d expected 4", count);
        end
        drain(ok);
        checks++;
        if (!ok || rx_q.size() != base + 5) begin
            errors++;
            $display("FAIL burst_rx_count got=%0d ok=%b expected 5", rx_q.size() - base, ok);
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (rx_q[base + i] !== 8'(i + 1)) begin
                    errors++;
                    $display("FAIL burst_rx_order idx=%0d got=%h expected %h", i, rx_q[base + i], 8'(i + 1));
                end
            end
        end
    endtask

    task automatic test_overflow();
        bit ok;
        int base = rx_q.size();
        force_active = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 17; i++) wr(8'h40 + 8'(i));
        checks++;
        if (full !== 1'b1 || count !== 5'd16 || ovf !== 1'b1) begin
            errors++;
            $display("FAIL overflow_flags full=%b count=%0d ovf=%b expected 1 16 1", full, count, ovf);
        end
        force_active = 1'b0;
        drain(ok);
        checks++;
        if (!ok || rx_q.size() != base + 16) begin
            errors++;
            $display("FAIL overflow_rx_count got=%0d ok=%b expected 16", rx_q.size() - base, ok);
        end else begin
            for (int i = 0; i < 16; i++) begin
                checks++;
                if (rx_q[base + i] !== 8'h40 + 8'(i)) begin
                    errors++;
                    $display("FAIL overflow_rx_order idx=%0d got=%h expected %h", i, rx_q[base + i], 8'h40 + 8'(i));
                end
            end
        end
    endtask

    task automatic test_simultaneous();
        bit         ok;
        bit         found = 0;
        int         base;
        logic [7:0] sent [$];
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        base = rx_q.size();
        force_active = 1'b1;
        for (int i = 0; i < 16; i++) begin
            sent.push_back(8'($urandom_range(255, 0)));
            wr(sent[i]);
        end
        checks++;
        if (full !== 1'b1 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL simul_fill full=%b ovf=%b expected 1 0", full, ovf);
        end
        force_active = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (tx_dv) begin
                found = 1;
                break;
            end
            @(posedge clk); #1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL simul_launch seen=0 expected 1");
        end
        wr(8'hEE);
        checks++;
        if (count !== 5'd15 || ovf !== 1'b1 || full !== 1'b0) begin
            errors++;
            $display("FAIL simul_drop count=%0d ovf=%b full=%b expected 15 1 0", count, ovf, full);
        end
        drain(ok);
        checks++;
        if (!ok || rx_q.size() != base + 16) begin
            errors++;
            $display("FAIL simul_rx_count got=%0d ok=%b expected 16", rx_q.size() - base, ok);
        end else begin
            for (int i = 0; i < 16; i++) begin
                checks++;
                if (rx_q[base + i] !== sent[i]) begin
                    errors++;
                    $display("FAIL simul_rx_order idx=%0d got=%h expected %h", i, rx_q[base + i], sent[i]);
                end
            end
        end
    endtask

    task automatic test_wrap();
        bit         ok;
        int         base = rx_q.size();
        logic [7:0] sent [$];
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 12; i++) begin
                logic [7:0] b = 8'($urandom_range(255, 0));
                sent.push_back(b);
                wr(b);
                repeat ($urandom_range(2, 0)) begin
                    @(posedge clk); #1;
                end
            end
            drain(ok);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL wrap_drain round=%0d timeout=1 expected 0", r);
            end
        end
        checks++;
        if (rx_q.size() != base + 36) begin
            errors++;
            $display("FAIL wrap_rx_count got=%0d expected 36", rx_q.size() - base);
        end else begin
            for (int i = 0; i < 36; i++) begin
                checks++;
                if (rx_q[base + i] !== sent[i]) begin
                    errors++;
                    $display("FAIL wrap_rx_order idx=%0d got=%h expected %h", i, rx_q[base + i], sent[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        bit ok;
        bit found = 0;
        bit early = 0;
        int base;
        wr(8'h77);
        for (int i = 0; i < 10; i++) begin
            if (tx_dv) begin
                found = 1;
                break;
            end
            @(posedge clk); #1;
        end
        repeat (8) @(posedge clk);
        #1;
        checks++;
        if (!found || tx_active !== 1'b1) begin
            errors++;
            $display("FAIL rmf_in_flight launched=%b active=%b expected 1 1", found, tx_active);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if ({full, empty, count, ovf, tx_dv, tx_byte, busy} !==
            {1'b0, 1'b1, {(ADDR_W + 1){1'b0}}, 1'b0, 1'b0, 8'h00, 1'b0}) begin
            errors++;
            $display("FAIL rmf_reset_values full=%b empty=%b count=%0d ovf=%b dv=%b byte=%h busy=%b expected 0 1 0 0 0 00 0",
                     full, empty, count, ovf, tx_dv, tx_byte, busy);
        end
        // A Done pulse while idle must not start a gap.
        force_done = 1'b1;
        @(posedge clk); #1;
        force_done = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL rmf_stray_done busy=%b expected 0", busy);
        end
        wr(8'hA5);
        for (int i = 0; i < 200 && tx_active; i++) begin
            if (tx_dv) early = 1;
            @(posedge clk); #1;
        end
        checks++;
        if (early || tx_active) begin
            errors++;
            $display("FAIL rmf_wait_active early_dv=%b active=%b expected 0 0", early, tx_active);
        end
        base = rx_q.size();
        drain(ok);
        checks++;
        if (!ok || rx_q.size() != base + 1 || rx_q[base] !== 8'hA5) begin
            errors++;
            $display("FAIL rmf_fresh_byte rx_count=%0d ok=%b expected 1 byte a5", rx_q.size() - base, ok);
        end
    endtask

    initial begin
        rst          = 1'b1;
        wr_dv        = 1'b0;
        wr_byte      = 8'h00;
        force_active = 1'b0;
        force_done   = 1'b0;
        test_reset();
        fork
            monitor();
        join_none
        test_single_byte();
        test_burst();
        test_overflow();
        test_simultaneous();
        test_wrap();
        test_reset_mid_frame();
        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
